fifo_bit_collector: RTL and testbench

Read-side companion to the team's 1-bit FIFO. The block drains the FIFO one bit at a time using its `pop`/`empty`/`data_out` interface and assembles the bits LSB-first into WIDTH-bit words. Each word is presented downstream on a valid/ready handshake. An optional flush emits a partial word, so a trailing fragment can be delivered without waiting for WIDTH bits.

---
 rtl/fifo_rd_pkg.sv | 16 +
 rtl/fifo_bit_collector.sv | 136 +++++++++++++
 tb/tb_fifo_bit_collector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the read side of the 1-bit FIFO.
//   coll_state_t : collector FSM states (collect bits / hold finished word)
//   MAX_WIDTH    : largest word width the collector supports
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_HOLD    = 1'b1
   } coll_state_t;

   localparam int MAX_WIDTH = 32;

endpackage : fifo_rd_pkg

// File: rtl/fifo_bit_collector.sv
// ---------------------------------------------------------------------------
// fifo_bit_collector
// Drains a 1-bit FIFO one bit per cycle and assembles the bits LSB-first
// into WIDTH-bit words. Each word is offered on a valid/ready handshake. A
// flush request emits the bits gathered so far as a shorter word.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO head bit, valid while fifo_empty=0
//   fifo_pop    out  pop strobe; the head bit is consumed at the same edge
//   flush       in   emit the partial word collected so far
//   word_valid  out  word_data/word_len hold a word
//   word_ready  in   downstream accepts the word
//   word_data   out  assembled word, first popped bit in bit 0
//   word_len    out  number of valid bits in word_data (1..WIDTH)
// ---------------------------------------------------------------------------
module fifo_bit_collector
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fifo_empty,
   input  logic                         fifo_data,
   output logic                         fifo_pop,
   input  logic                         flush,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic [WIDTH-1:0]             word_data,
   output logic [$clog2(WIDTH+1)-1:0]   word_len
);

   localparam int CW = $clog2(WIDTH + 1);

   generate
      if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
         $error("fifo_bit_collector: WIDTH must be in 2..MAX_WIDTH");
      end
   endgenerate

   coll_state_t         r_state;
   coll_state_t         w_state_nxt;
   logic [CW-1:0]       r_bit_cnt;
   logic [CW-1:0]       w_bit_cnt_nxt;
   logic [WIDTH-1:0]    r_shift;
   logic [WIDTH-1:0]    w_shift_nxt;
   logic [CW-1:0]       r_len;
   logic [CW-1:0]       w_len_nxt;
   logic                r_valid;
   logic                w_valid_nxt;
   logic                w_pop;
   logic [WIDTH-1:0]    w_bit_mask;
   logic                w_last_bit;

   // Pop only while collecting; reset overrides so the FIFO is never touched.
   assign w_pop      = !rst && (r_state == S_COLLECT) && !fifo_empty;
   // Shift register is cleared between words, so OR-ing in the new bit is enough.
   assign w_bit_mask = WIDTH'(fifo_data) << r_bit_cnt;
   assign w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));

   // Next-state and datapath update for the collect/hold FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_len_nxt     = r_len;
      w_valid_nxt   = r_valid;
      case (r_state)
         S_COLLECT: begin
            if (w_pop) begin
               w_shift_nxt   = r_shift | w_bit_mask;
               w_bit_cnt_nxt = r_bit_cnt + CW'(1);
               if (w_last_bit || flush) begin
                  // Popped bit is part of the word, full or flushed.
                  w_len_nxt   = r_bit_cnt + CW'(1);
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_COLLECT;
               end
            end else if (flush && (r_bit_cnt != CW'(0))) begin
               w_len_nxt   = r_bit_cnt;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_HOLD;
            end else begin
               // Flush with nothing collected never yields an empty word.
               w_state_nxt = S_COLLECT;
            end
         end
         S_HOLD: begin
            if (word_ready) begin
               w_shift_nxt   = '0;
               w_bit_cnt_nxt = '0;
               w_len_nxt     = '0;
               w_valid_nxt   = 1'b0;
               w_state_nxt   = S_COLLECT;
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         default: begin
            w_shift_nxt   = '0;
            w_bit_cnt_nxt = '0;
            w_len_nxt     = '0;
            w_valid_nxt   = 1'b0;
            w_state_nxt   = S_COLLECT;
         end
      endcase
   end

   // State, counter, shift and length registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_COLLECT;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_len     <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_len     <= w_len_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   assign fifo_pop   = w_pop;
   assign word_valid = r_valid;
   assign word_data  = r_shift;
   assign word_len   = r_len;

endmodule : fifo_bit_collector

// File: tb/tb_fifo_bit_collector.sv
// ---------------------------------------------------------------------------
// tb_fifo_bit_collector
// Self-checking bench for fifo_bit_collector (WIDTH=8). A behavioural FIFO
// feeds bits; expected words are pushed to a scoreboard as stimulus is set up
// and compared whenever the DUT shows a valid word.
// ---------------------------------------------------------------------------
module tb_fifo_bit_collector;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst;
   logic             fifo_empty;
   logic             fifo_data;
   logic             fifo_pop;
   logic             flush;
   logic             word_valid;
   logic             word_ready;
   logic [WIDTH-1:0] word_data;
   logic [CW-1:0]    word_len;

   fifo_bit_collector #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_pop   (fifo_pop),
      .flush      (flush),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_len   (word_len)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int unsigned data;
      int unsigned len;
   } word_t;

   bit    fq[$];        // FIFO contents, head at index 0
   word_t sb[$];        // expected words
   int    checks   = 0;
   int    failures = 0;
   int    pop_cnt  = 0;
   int    vcnt     = 0;

   // reference collector state, used for expected pop/valid
   bit    m_hold = 1'b0;
   int    m_cnt  = 0;

   task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_bits(input int unsigned bits, input int n);
      for (int i = 0; i < n; i++) fq.push_back(bits[i]);
   endtask

   // One clock cycle: drive at negedge, check, then update the model after the edge.
   task automatic step(input bit r, input bit gap, input bit fl, input bit rdy);
      bit    empty_v;
      bit    pop_e;
      bit    pop_s;
      empty_v    = gap || (fq.size() == 0);
      rst        = r;
      fifo_empty = empty_v;
      fifo_data  = (fq.size() != 0) ? fq[0] : 1'b0;
      flush      = fl;
      word_ready = rdy;
      #1;
      pop_e = !r && !m_hold && !empty_v;
      check_val("fifo_pop", fifo_pop, pop_e);
      if (!r) begin
         check_val("word_valid", word_valid, m_hold);
         if (word_valid === 1'b1) begin
            vcnt++;
            if (sb.size() == 0) begin
               check_val("unexpected_word", word_data, 32'hFFFF_FFFF);
            end else begin
               check_val("word_data", word_data, sb[0].data);
               check_val("word_len", word_len, sb[0].len);
               if (rdy) void'(sb.pop_front());
            end
         end
      end
      pop_s = (fifo_pop === 1'b1);
      @(posedge clk);
      #1;
      if (pop_s && fq.size() != 0) begin
         void'(fq.pop_front());
         pop_cnt++;
      end
      if (r) begin
         m_hold = 1'b0;
         m_cnt  = 0;
      end else if (m_hold) begin
         if (rdy) begin
            m_hold = 1'b0;
            m_cnt  = 0;
         end
      end else if (pop_e) begin
         m_cnt++;
         if (m_cnt == WIDTH || fl) m_hold = 1'b1;
      end else if (fl && m_cnt > 0) begin
         m_hold = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      fifo_empty = 1'b1;
      fifo_data  = 1'b0;
      flush      = 1'b0;
      word_ready = 1'b0;
      @(negedge clk);

      // Reset for two cycles with data waiting: no pops allowed.
      push_bits(32'h0000_004D, 8);     // 1,0,1,1,0,0,1,0
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      check_val("rst_valid", word_valid, 0);
      check_val("rst_data", word_data, 0);
      check_val("rst_len", word_len, 0);

      // Full word back-to-back.
      sb.push_back('{32'h4D, 8});
      pop_cnt = 0;
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("full_pops", pop_cnt, 8);
      check_val("full_sb_empty", sb.size(), 0);

      // Gaps on the FIFO side and 5 cycles of backpressure, two words.
      push_bits(32'h0000_008E, 8);
      push_bits(32'h0000_000F, 8);
      sb.push_back('{32'h8E, 8});
      sb.push_back('{32'h0F, 8});
      pop_cnt = 0;
      vcnt    = 0;
      for (int i = 0; i < 60; i++) step(1'b0, i[0], 1'b0, (vcnt >= 5));
      check_val("bp_pops", pop_cnt, 16);
      check_val("bp_sb_empty", sb.size(), 0);

      // Flush alone after 1,1,0.
      push_bits(32'h0000_0003, 3);
      sb.push_back('{32'h03, 3});
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("flush_sb_empty", sb.size(), 0);

      // Flush with nothing collected produces no word.
      vcnt = 0;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("flush_empty_noword", vcnt, 0);

      // Flush coincident with the third pop (1,0,1).
      push_bits(32'h0000_0005, 3);
      sb.push_back('{32'h05, 3});
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("flush_pop_sb_empty", sb.size(), 0);

      // Reset after 5 bits: the next word needs 8 fresh pops.
      push_bits(32'h0000_001F, 5);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      push_bits(32'h0000_0080, 8);
      sb.push_back('{32'h80, 8});
      pop_cnt = 0;
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("rst_mid_pops", pop_cnt, 8);
      check_val("rst_mid_sb_empty", sb.size(), 0);

      // Reset while holding a word with ready low: the word is dropped.
      push_bits(32'h0000_00FF, 8);
      sb.push_back('{32'hFF, 8});
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("hold_valid_before_rst", word_valid, 1);
      void'(sb.pop_front());
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("hold_valid_after_rst", word_valid, 0);
      check_val("hold_data_after_rst", word_data, 0);
      vcnt = 0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      check_val("hold_dropped", vcnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_bit_collector
